full_handshake_tx_arb: RTL
==========================

Name: full_handshake_tx_arb

Overview:
- Transmit-side controller for the four-phase (full) handshake CDC link used by the debug path.
- Arbitrates between NUM_REQ local requesters in round-robin order and drives the single vld/data pair toward the receiver in the other clock domain.
- Double-flop synchronises the returning rdy and sequences the four phases: vld=1, rdy=1, vld=0, rdy=0.
- Holds data stable for the full transaction, so only the single-bit control signals cross domains.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- DATA_WIDTH, 40: payload width, matching the receiver.
- ID_WIDTH, 3: width of the grant index; must satisfy 2^ID_WIDTH >= NUM_REQ.

Ports:
- clk  in  1  single clock, all flops rising-edge.
- rst  in  1  asynchronous active-high reset.
- i_req_vld  in  NUM_REQ  per-requester request; held until own o_req_ack pulse.
- i_req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester k uses bits [k*DATA_WIDTH +: DATA_WIDTH]; stable while i_req_vld[k]=1.
- o_req_ack  out  NUM_REQ  one-cycle pulse; payload captured, requester may drop vld.
- o_vld  out  1  registered handshake request to the far domain.
- o_data  out  DATA_WIDTH  registered payload to the far domain.
- i_rdy  in  1  asynchronous acknowledge from the far domain.
- o_grant_id  out  ID_WIDTH  index of the requester owning the current or last transfer.
- o_busy  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle pulse when a transfer fully completes (rdy returned low).

Behaviour:
- Reset (asynchronous, immediate): o_vld=0, o_data=0, o_req_ack=0, o_grant_id=0, o_busy=0, o_done=0, rr_ptr=0, both rdy sync flops=0, state=IDLE.
- Synchroniser: rdy_d <= i_rdy; rdy_s <= rdy_d. Only rdy_s is used by the FSM.
- FSM states: IDLE, ASSERT, DEASSERT.
- IDLE:
  - If any i_req_vld bit is set, grant g = first set index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On that edge: o_data <= payload[g]; o_vld <= 1; o_req_ack[g] pulses for 1 cycle; o_grant_id <= g; rr_ptr <= (g+1) mod NUM_REQ; go to ASSERT.
  - If no request is pending, stay in IDLE and all outputs hold.
- ASSERT: wait for rdy_s=1. On that edge o_vld <= 0 and go to DEASSERT. o_data holds.
- DEASSERT: wait for rdy_s=0. On that edge o_done pulses 1 cycle and go to IDLE.
- o_data is never cleared after reset. It holds the last payload until the next grant, so it is stable across the far side's sampling window.
- Latency:
  - Request to o_vld=1: 1 cycle.
  - i_rdy rise to o_vld fall: 3 edges (2 sync + 1 FSM).
  - i_rdy fall to o_done: 3 edges.
- Back-to-back:
  - At least 1 IDLE cycle separates transfers; the cycle after o_done may grant.
  - Per-transfer minimum is 7 cycles with an instant far side.
- Simultaneous requests: exactly one grant per transfer. A requester not granted keeps its request and is served in round-robin order. No requester waits more than NUM_REQ-1 transfers.
- i_req_vld deasserting before its ack is a protocol violation; behaviour is undefined and no check is required.
- i_rdy is ignored in IDLE. A spurious rdy_s=1 in IDLE does not block a grant; the FSM still waits in ASSERT for rdy_s=1.
- Reset mid-transfer: o_vld drops immediately and the pending transfer is lost with no ack/done replay. System requirement: the receiver domain is reset in the same window.
- No timeout: a stuck i_rdy holds the FSM indefinitely with o_busy=1.

Test Plan:
- Single transfer: NUM_REQ=2, i_req_vld=2'b01, data0=40'h12_3456_789A; far model raises i_rdy 4 cycles after o_vld and drops it 4 cycles after o_vld falls.
  -> o_req_ack=2'b01 for 1 cycle; o_vld=1 with o_data=40'h12_3456_789A; o_vld falls 3 cycles after i_rdy rises; o_done pulses 3 cycles after i_rdy falls; o_grant_id=0.
- Contention: both requesters held high for 4 transfers.
  -> grant order 0,1,0,1; each o_req_ack pulse is one-hot; o_data matches the granted payload.
- Round-robin pointer: after requester 1 is served, raise both requesters.
  -> requester 0 is granted first; repeat with NUM_REQ=4 and requests 4'b1010 after grant 1 -> next grant is 3.
- Slow far side: i_rdy held high for 50 cycles.
  -> o_vld stays 0, o_busy stays 1, o_data unchanged, no second grant until rdy_s=0 and then one IDLE cycle.
- Reset mid-ASSERT: assert rst while o_vld=1.
  -> o_vld=0, o_busy=0, o_grant_id=0 in the same cycle (asynchronous); after release, a new request is granted starting from index 0.
- Spurious rdy: i_rdy=1 while IDLE, then request 1.
  -> grant occurs; o_vld falls only after rdy_s is seen high in ASSERT; no o_done before i_rdy has gone low.

Source files
------------

// File: rtl/full_handshake_tx_arb.sv
// Transmit side of the four-phase CDC debug link: round-robin picks one local
// requester, launches vld/data to the far domain and sequences vld/rdy to completion.
module full_handshake_tx_arb #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 40,
    parameter int ID_WIDTH   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req_vld,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ack,
    output logic                          o_vld,
    output logic [DATA_WIDTH-1:0]         o_data,
    input  logic                          i_rdy,
    output logic [ID_WIDTH-1:0]           o_grant_id,
    output logic                          o_busy,
    output logic                          o_done
);

    typedef enum logic [1:0] {IDLE, ASSERT, DEASSERT} state_t;

    state_t                state, state_nx;
    logic                  rdy_d, rdy_s;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic                  gnt_any;
    logic [ID_WIDTH-1:0]   gnt_id, gnt_nxt_ptr;
    logic [NUM_REQ-1:0]    gnt_oh;
    logic [DATA_WIDTH-1:0] gnt_data;

    // Winner is the set requester with the smallest forward distance from rr_ptr.
    always_comb begin : rr_pick
        int best;
        int d;
        best        = NUM_REQ;
        d           = 0;
        gnt_any     = 1'b0;
        gnt_id      = '0;
        gnt_nxt_ptr = '0;
        gnt_oh      = '0;
        gnt_data    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            d = (k + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
            if (i_req_vld[k] && d < best) begin
                best        = d;
                gnt_any     = 1'b1;
                gnt_id      = ID_WIDTH'(k);
                gnt_nxt_ptr = ID_WIDTH'((k + 1) % NUM_REQ);
                gnt_oh      = NUM_REQ'(1) << k;
                gnt_data    = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_d <= 1'b0;
            rdy_s <= 1'b0;
        end else begin
            rdy_d <= i_rdy;
            rdy_s <= rdy_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (gnt_any) state_nx = ASSERT;
            ASSERT:   if (rdy_s)   state_nx = DEASSERT;
            DEASSERT: if (!rdy_s)  state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    // o_data is only reloaded on a grant so it stays put for the far side's sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vld      <= 1'b0;
            o_data     <= '0;
            o_req_ack  <= '0;
            o_grant_id <= '0;
            o_done     <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            o_req_ack <= '0;
            o_done    <= 1'b0;
            case (state)
                IDLE: if (gnt_any) begin
                    o_data     <= gnt_data;
                    o_vld      <= 1'b1;
                    o_req_ack  <= gnt_oh;
                    o_grant_id <= gnt_id;
                    rr_ptr     <= gnt_nxt_ptr;
                end
                ASSERT:   if (rdy_s)  o_vld  <= 1'b0;
                DEASSERT: if (!rdy_s) o_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign o_busy = (state != IDLE);

endmodule
